cla_pipe_adder: RTL and testbench

CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

---
 rtl/cla_pkg.sv | 16 +
 rtl/cla_group.sv | 39 +++
 rtl/cla_pipe_adder.sv | 179 +++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants and helpers for the pipelined lookahead adder
package cla_pkg;

    localparam int DEF_NBIT = 16;
    localparam int DEF_BLK  = 4;

    // Operation select encoding on the sub input
    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // Number of BLK-bit lookahead groups across an NBIT operand
    function automatic int group_count(input int nbit, input int blk);
        return nbit / blk;
    endfunction

endpackage

// File: rtl/cla_group.sv
// rtl/cla_group.sv - combinational BLK-bit carry-lookahead cell
module cla_group #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] g,
    input  logic [BLK-1:0] p,
    input  logic           cin,
    output logic           gg,
    output logic           gp,
    output logic [BLK-1:0] c
);

    // c[i] is the carry into bit i, written as a flat sum of products so no
    // carry ripples through the cell; gg/gp summarise the whole block.
    always_comb begin : lookahead
        logic term;
        term = 1'b0;
        c    = '0;
        gg   = 1'b0;
        gp   = 1'b1;
        for (int i = 0; i < BLK; i++) begin
            term = cin;
            for (int k = 0; k < i; k++) term = term & p[k];
            c[i] = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int k = j + 1; k < i; k++) term = term & p[k];
                c[i] = c[i] | term;
            end
        end
        for (int j = 0; j < BLK; j++) begin
            term = g[j];
            for (int k = j + 1; k < BLK; k++) term = term & p[k];
            gg = gg | term;
            gp = gp & p[j];
        end
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - 3-stage elastic two-level carry-lookahead adder/subtractor
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int NBIT = DEF_NBIT,
    parameter int BLK  = DEF_BLK
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    input  logic            c,
    input  logic            sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NBIT-1:0] sum,
    output logic            cout,
    output logic            ovf
);

    localparam int NGRP = group_count(NBIT, BLK);

    logic            v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic            ld1, ld2, ld3;
    logic [NBIT-1:0] b_eff;
    logic            cin_eff;

    logic [NBIT-1:0] g1_q, g1_d, p1_q, p1_d;
    logic            cin1_q, cin1_d;

    logic [NBIT-1:0] g2_q, g2_d, p2_q, p2_d;
    logic [NGRP-1:0] grp_g2_q, grp_g2_d, grp_p2_q, grp_p2_d, grp_c2_q, grp_c2_d;

    logic [NBIT-1:0] sum_q, sum_d;
    logic            cout_q, cout_d, ovf_q, ovf_d;

    logic [NGRP-1:0] grp_g, grp_p, grp_c;
    logic [NBIT-1:0] lvl1_c_unused;
    logic            top_g_unused, top_p_unused;
    logic [NBIT-1:0] bit_c;
    logic [NGRP-1:0] s3_gg_unused, s3_gp_unused;
    logic            carry_out;

    // Elastic handshake: a stage loads when empty or when the stage after it moves
    always_comb begin
        ld3      = ~v3_q | out_ready;
        ld2      = ~v2_q | ld3;
        ld1      = ~v1_q | ld2;
        in_ready = ld1 & ~rst;
        v1_d     = ld1 ? in_valid : v1_q;
        v2_d     = ld2 ? v1_q     : v2_q;
        v3_d     = ld3 ? v2_q     : v3_q;
    end

    // S1: bitwise generate/propagate against the (possibly inverted) B operand
    always_comb begin
        b_eff   = b;
        cin_eff = c;
        case (sub)
            ADD:     begin b_eff = b;  cin_eff = c;    end
            SUB:     begin b_eff = ~b; cin_eff = 1'b1; end
            default: begin b_eff = b;  cin_eff = c;    end
        endcase
        g1_d   = g1_q;
        p1_d   = p1_q;
        cin1_d = cin1_q;
        if (ld1 && in_valid) begin
            g1_d   = a & b_eff;
            p1_d   = a ^ b_eff;
            cin1_d = cin_eff;
        end
    end

    // First-level group G/P, then the second level turns them into group carry-ins
    for (genvar gi = 0; gi < NGRP; gi++) begin : g_lvl1
        cla_group #(.BLK(BLK)) u_grp (
            .g   (g1_q[gi*BLK +: BLK]),
            .p   (p1_q[gi*BLK +: BLK]),
            .cin (1'b0),
            .gg  (grp_g[gi]),
            .gp  (grp_p[gi]),
            .c   (lvl1_c_unused[gi*BLK +: BLK])
        );
    end

    cla_group #(.BLK(NGRP)) u_lvl2 (
        .g   (grp_g),
        .p   (grp_p),
        .cin (cin1_q),
        .gg  (top_g_unused),
        .gp  (top_p_unused),
        .c   (grp_c)
    );

    // S2: capture bit g/p alongside the group G/P and group carry-ins
    always_comb begin
        g2_d     = g2_q;
        p2_d     = p2_q;
        grp_g2_d = grp_g2_q;
        grp_p2_d = grp_p2_q;
        grp_c2_d = grp_c2_q;
        if (ld2 && v1_q) begin
            g2_d     = g1_q;
            p2_d     = p1_q;
            grp_g2_d = grp_g;
            grp_p2_d = grp_p;
            grp_c2_d = grp_c;
        end
    end

    // Per-bit carries inside each group from its registered carry-in
    for (genvar gi = 0; gi < NGRP; gi++) begin : g_lvl3
        cla_group #(.BLK(BLK)) u_grp (
            .g   (g2_q[gi*BLK +: BLK]),
            .p   (p2_q[gi*BLK +: BLK]),
            .cin (grp_c2_q[gi]),
            .gg  (s3_gg_unused[gi]),
            .gp  (s3_gp_unused[gi]),
            .c   (bit_c[gi*BLK +: BLK])
        );
    end

    // S3: sum bits, carry out of the MSB group chain, and signed overflow
    always_comb begin
        carry_out = grp_c2_q[0];
        for (int i = 0; i < NGRP; i++) carry_out = grp_g2_q[i] | (grp_p2_q[i] & carry_out);
        sum_d  = sum_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        if (ld3 && v2_q) begin
            sum_d  = p2_q ^ bit_c;
            cout_d = carry_out;
            ovf_d  = bit_c[NBIT-1] ^ carry_out;
        end
    end

    // All pipeline state, cleared asynchronously so in-flight beats vanish at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            g1_q     <= '0;
            p1_q     <= '0;
            cin1_q   <= 1'b0;
            g2_q     <= '0;
            p2_q     <= '0;
            grp_g2_q <= '0;
            grp_p2_q <= '0;
            grp_c2_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            v3_q     <= v3_d;
            g1_q     <= g1_d;
            p1_q     <= p1_d;
            cin1_q   <= cin1_d;
            g2_q     <= g2_d;
            p2_q     <= p2_d;
            grp_g2_q <= grp_g2_d;
            grp_p2_q <= grp_p2_d;
            grp_c2_q <= grp_c2_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_valid = v3_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - self-checking bench for cla_pipe_adder
module tb_cla_pipe_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        in_valid, in_ready, c, sub, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, sum;
    logic        start_rand = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    cla_pipe_adder #(.NBIT(16), .BLK(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Randomised streaming against a reference model, one DUT per width/group pair
    for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
        localparam int NB = (gi == 0) ? 16 : (gi == 1) ? 8 : 32;
        localparam int BK = (gi == 0) ? 4  : (gi == 1) ? 2 : 8;

        logic          iv, ir, ov, ordy, cc, sb, co, of;
        logic [NB-1:0] aa, bb, ss;
        logic          done = 1'b0;

        cla_pipe_adder #(.NBIT(NB), .BLK(BK)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv),
            .in_ready  (ir),
            .a         (aa),
            .b         (bb),
            .c         (cc),
            .sub       (sb),
            .out_valid (ov),
            .out_ready (ordy),
            .sum       (ss),
            .cout      (co),
            .ovf       (of)
        );

        function automatic logic [71:0] ref_model(input logic [63:0] x, input logic [63:0] y,
                                                  input logic ci, input logic s);
            logic [64:0] mask, bx, full;
            logic        rco, rov;
            mask = (65'd1 << NB) - 65'd1;
            bx   = s ? (~{1'b0, y} & mask) : ({1'b0, y} & mask);
            full = ({1'b0, x} & mask) + bx + (s ? 65'd1 : {64'd0, ci});
            rco  = full[NB];
            rov  = (x[NB-1] == bx[NB-1]) && (full[NB-1] != x[NB-1]);
            return {6'd0, rco, rov, full[63:0] & mask[63:0]};
        endfunction

        initial begin
            logic [71:0] q[$];
            logic [71:0] exp_v;
            int          sent, got, bubbles;
            logic        pending, started;
            sent = 0; got = 0; bubbles = 0; pending = 1'b0; started = 1'b0;
            iv = 1'b0; ordy = 1'b0; cc = 1'b0; sb = 1'b0; aa = '0; bb = '0;
            wait (start_rand);
            for (int cyc = 0; cyc < 6000 && got < 1000; cyc++) begin
                @(negedge clk);
                ordy = 1'($urandom_range(0, 1));
                if (!pending && sent < 1000) begin
                    aa = NB'($urandom);
                    bb = NB'($urandom);
                    cc = 1'($urandom_range(0, 1));
                    sb = 1'($urandom_range(0, 1));
                    pending = 1'b1;
                end
                iv = pending;
                #1;
                if (iv && ir) begin
                    q.push_back(ref_model(64'(aa), 64'(bb), cc, sb));
                    sent++;
                    pending = 1'b0;
                end
                if (ov && ordy) begin
                    exp_v = (q.size() > 0) ? q.pop_front() : '1;
                    check($sformatf("rand%0d_result", gi), {6'd0, co, of, 64'(ss)}, exp_v);
                    got++;
                end
                if (ov) started = 1'b1;
                if (started && sent < 1000 && ordy && !ov) bubbles++;
            end
            iv = 1'b0;
            check($sformatf("rand%0d_count", gi), 72'(got), 72'(1000));
            check($sformatf("rand%0d_bubbles", gi), 72'(bubbles), 72'(0));
            check($sformatf("rand%0d_leftover", gi), 72'(q.size()), 72'(0));
            done = 1'b1;
        end
    end

    // One directed beat with an empty pipe; checks latency and result fields
    task automatic op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                      input logic tc, input logic tsub,
                      input logic [15:0] es, input logic ec, input logic eo);
        @(negedge clk);
        a = ta; b = tb_; c = tc; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 72'(in_ready), 72'(1'b1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_lat1"}, 72'(out_valid), 72'(1'b0));
        @(negedge clk);
        check({tag, "_lat2"}, 72'(out_valid), 72'(1'b0));
        @(negedge clk);
        check({tag, "_valid"}, 72'(out_valid), 72'(1'b1));
        check({tag, "_sum"}, 72'(sum), 72'(es));
        check({tag, "_cout"}, 72'(cout), 72'(ec));
        check({tag, "_ovf"}, 72'(ovf), 72'(eo));
    endtask

    logic acc;
    int   idx, got, seen;

    initial begin
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; c = 1'b0; sub = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 72'(out_valid), 72'(1'b0));
        check("rst_in_ready", 72'(in_ready), 72'(1'b0));
        check("rst_sum", 72'(sum), 72'(16'h0000));
        check("rst_cout_ovf", 72'({cout, ovf}), 72'(2'b00));
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 72'(in_ready), 72'(1'b1));

        op("ffff_plus_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        op("8000_minus_1", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        op("0_minus_1", 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        op("add_cin", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        op("sub_equal", 16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        op("sub_ign_c", 16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);

        // Backpressure: four beats offered, downstream stalled for six cycles
        idx = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            out_ready = 1'b0; c = 1'b0; sub = 1'b0;
            in_valid = (idx < 4);
            a = 16'(idx + 1); b = 16'(idx + 1);
            #1;
            if (cyc == 3) check("bp_full_in_ready", 72'(in_ready), 72'(1'b0));
            if (cyc == 5) check("bp_hold_sum", 72'({out_valid, sum}), 72'({1'b1, 16'd2}));
            acc = in_valid & in_ready;
            @(posedge clk);
            if (acc) idx++;
        end
        check("bp_accepted", 72'(idx), 72'(3));
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = (idx < 4);
            a = 16'(idx + 1); b = 16'(idx + 1);
            #1;
            if (cyc == 0) check("bp_accept_with_drain", 72'(in_ready), 72'(1'b1));
            acc = in_valid & in_ready;
            if (out_valid) begin
                check($sformatf("bp_order%0d", got), 72'(sum), 72'(16'(2 * (got + 1))));
                got++;
            end
            @(posedge clk);
            if (acc) idx++;
        end
        check("bp_count", 72'(got), 72'(4));

        // Reset with three beats in flight
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            out_ready = 1'b0; in_valid = 1'b1;
            a = 16'(16'h0100 + cyc); b = 16'h0001;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 72'(out_valid), 72'(1'b0));
        check("mid_rst_in_ready", 72'(in_ready), 72'(1'b0));
        check("mid_rst_sum", 72'(sum), 72'(16'h0000));
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        seen = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mid_rst_no_stale", 72'(seen), 72'(0));

        start_rand = 1'b1;
        for (int cyc = 0; cyc < 20000 && !(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done); cyc++)
            @(posedge clk);
        check("rand_all_done", 72'({g_cfg[0].done, g_cfg[1].done, g_cfg[2].done}), 72'(3'b111));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
